// File: rtl/btb_update_arbiter.sv
// Serialises branch-mispredict reports from two execute pipes onto the single BTB update port.
// Reports pass through a small in-order FIFO; same-cycle reports for the same PC are merged.
module btb_update_arbiter #(
  parameter int DEPTH  = 4,
  parameter int TYPE_W = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [31:0]                req0_pc,
  input  logic [31:0]                req0_target,
  input  logic [TYPE_W-1:0]          req0_type,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [31:0]                req1_pc,
  input  logic [31:0]                req1_target,
  input  logic [TYPE_W-1:0]          req1_type,
  input  logic                       drain_hold,
  output logic                       btb_mistaken,
  output logic [31:0]                btb_wrong_pc,
  output logic [31:0]                btb_right_target,
  output logic [TYPE_W-1:0]          btb_ins_type,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]       pc_mem     [DEPTH];
  logic [31:0]       target_mem [DEPTH];
  logic [TYPE_W-1:0] type_mem   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tail1;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  free;
  logic              merge;
  logic              push0;
  logic              push1;
  logic              pop;

  // Readiness depends only on the registered count, never on this cycle's pop.
  always_comb begin
    free       = CNT_W'(DEPTH) - count;
    merge      = req0_valid & req1_valid & (req0_pc[31:2] == req1_pc[31:2]);
    req0_ready = resetn & (free >= CNT_W'(1));
    if (merge) begin
      req1_ready = req0_ready;
    end else if (req0_valid) begin
      req1_ready = resetn & (free >= CNT_W'(2));
    end else begin
      req1_ready = resetn & (free >= CNT_W'(1));
    end
    push0      = req0_valid & req0_ready;
    push1      = req1_valid & req1_ready & ~merge;
    pop        = (count != '0) & ~drain_hold;
    tail1      = tail + PTR_W'(push0);
    count_next = count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]     <= '0;
        target_mem[i] <= '0;
        type_mem[i]   <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push0) begin
        pc_mem[tail]     <= req0_pc;
        target_mem[tail] <= req0_target;
        type_mem[tail]   <= req0_type;
      end
      // req1 lands behind req0 when both are written in the same cycle.
      if (push1) begin
        pc_mem[tail1]     <= req1_pc;
        target_mem[tail1] <= req1_target;
        type_mem[tail1]   <= req1_type;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btb_mistaken     <= 1'b0;
      btb_wrong_pc     <= '0;
      btb_right_target <= '0;
      btb_ins_type     <= '0;
    end else begin
      btb_mistaken <= pop;
      if (pop) begin
        btb_wrong_pc     <= pc_mem[head];
        btb_right_target <= target_mem[head];
        btb_ins_type     <= type_mem[head];
      end
    end
  end

  assign occupancy = count;

endmodule
